pir_zone_motion_rgb: RTL and testbench
======================================

Name: pir_zone_motion_rgb

Overview:
Multi-channel, parametrised successor to the single-LED PIR hold indicator. Each of N_CH PIR zones gets its own "time-left" level counter, reloaded on motion and decremented over HOLD_MS. The counter drives a per-zone RGB LED through a shared PWM engine, using a runtime-selectable display mode: gradient, gradient with expiry-warning blink, solid, or idle-blue. The block sits between the per-zone pir_conditioner instances and the board RGB LED pins. It also exports per-zone expiry pulses and an any-active flag for temp_fan_ctrl.

Parameters:
CLK_HZ, 100_000_000, fabric clock frequency in Hz; MS_DIV = CLK_HZ/1000 must be >= 2.
N_CH, 2, number of zones/LEDs (1..8).
HOLD_MS, 15000, hold interval in ms; must match pir_conditioner hold.
PWM_W, 8, PWM/level width; LVL_MAX = 2^PWM_W - 1.
WARN_LVL, 32, warning threshold; mode 1 blinks while 0 < level < WARN_LVL.
BLINK_MS, 125, blink half-period in ms.

Ports:
clk  in  1  fabric clock
rst_n  in  1  synchronous reset, active-low
pir_rise  in  N_CH  per-zone 1-cycle motion pulse
pir_on  in  N_CH  per-zone recent-motion level
mode  in  2  display mode (0 gradient, 1 gradient+blink, 2 solid, 3 idle-blue); sampled every cycle
rgb_r  out  N_CH  red drive, active-high, registered
rgb_g  out  N_CH  green drive, active-high, registered
rgb_b  out  N_CH  blue drive, active-high, registered
expired  out  N_CH  1-cycle pulse when a zone level steps 1 -> 0
any_active  out  1  registered OR of pir_on

Behaviour:
- Reset: one clock, synchronous, active-low. Applies when rst_n=0 at a clk edge.
  - All outputs are 0.
  - Level counters, step counters, ms divider, blink counter and blink_phase are 0.
  - The PWM counter is 0.
- Reset mid-operation clears everything on the next edge. No reload survives reset.
- ms tick:
  - The divider counts 0..MS_DIV-1.
  - ms_tick is high for exactly one cycle when the divider wraps.
  - The first tick occurs MS_DIV cycles after rst_n rises.
- Step size: STEP_MS = max(1, HOLD_MS/LVL_MAX) (integer division). Each zone has its own step counter, width clog2(STEP_MS+1).
- Per-zone level update, in priority order:
  1. pir_rise[i]=1: level[i] <= LVL_MAX and step[i] <= 0. This applies even if ms_tick is high in the same cycle (rise wins) and even if level[i] is already nonzero (retrigger).
  2. ms_tick=1 and level[i]!=0:
     - If step[i]==STEP_MS-1: step[i] <= 0 and level[i] <= level[i]-1.
     - Otherwise step[i] increments.
  3. level[i]==0: hold; step[i] is frozen. No wrap below 0.
- expired[i] pulses the cycle after level[i] transitions 1 -> 0. A rise in that same cycle suppresses the pulse.
- Blink:
  - The blink counter counts ms_ticks 0..BLINK_MS-1.
  - blink_phase toggles on wrap. It is free-running and shared by all zones.
- Colour stage: registered, 1-cycle latency from level. Per zone:
  - mode 0: red = LVL_MAX - level; green = level; blue = 0.
  - mode 1: same as mode 0, but red and green are forced to 0 when 0<level<WARN_LVL and blink_phase=1.
  - mode 2: green = LVL_MAX; red = 0; blue = 0.
  - mode 3: red and green as in mode 0; blue = LVL_MAX only when pir_on[i]=0, otherwise 0.
- PWM:
  - A single PWM_W-bit free-running counter, wrapping LVL_MAX -> 0, shared by all zones.
  - Output register: rgb_x[i] <= gate & (pwm_cnt < x_level[i]).
  - gate = pir_on[i] for red and green; gate = 1 for blue.
  - A level of 0 gives always-off; LVL_MAX gives on for LVL_MAX of 2^PWM_W cycles (never 100%).
- Latency:
  - pir_on change to rgb change: 1 cycle.
  - pir_rise to colour change: 3 cycles (level, colour, output registers).
- Zones are fully independent. Simultaneous rises on several zones are all honoured in the same cycle.
- any_active <= |pir_on, registered. Its reset value is 0.

Test Plan:
Bench parameters for all scenarios: CLK_HZ=10_000 (MS_DIV=10), HOLD_MS=300, PWM_W=4 (LVL_MAX=15, STEP_MS=20), WARN_LVL=4, BLINK_MS=5, N_CH=2.
1. Reset and first tick: hold rst_n=0 for 5 cycles with pir_on=2'b11 -> all outputs 0 throughout. After release, ms_tick first fires 10 cycles later and any_active=1 one cycle after release.
2. Full decay, mode 0, zone 0: pulse pir_rise[0] with pir_on[0]=1.
   - level goes 15 -> 0 after 300 ms (3000 cycles).
   - expired[0] pulses exactly once.
   - At level 15, rgb_g[0] is high 15 of every 16 cycles and rgb_r[0]=0.
   - At level 0, rgb_r[0] is high 15/16 and rgb_g[0]=0.
   - Zone 1 stays dark.
3. Retrigger and collision: assert pir_rise[0] in the same cycle as an ms_tick that would decrement level 8 -> 7. Required: level = 15, step counter = 0, no expired pulse.
4. Mode 1 warning: let level reach 3. Required: rgb_r[0]/rgb_g[0] are forced low for 5 ms, then PWM for 5 ms, alternating. At level 4 there is no blinking.
5. Mode 3 idle: pir_on=2'b01 with both levels 0. Required: rgb_b[1] is high 15/16 of cycles, rgb_b[0]=0, all red/green of zone 1 are 0.
6. Reset mid-decay: drop rst_n for 1 cycle at level 9. Required: level=0, outputs 0, no expired pulse. Decay resumes only after a new pir_rise.

Source files
------------

// File: rtl/pir_zone_motion_rgb.sv
// pir_zone_motion_rgb: per-zone PIR hold levels that decay over HOLD_MS and
// drive one RGB LED per zone through a shared PWM engine. Four display modes
// are available: gradient, gradient with an expiry-warning blink, solid green,
// and idle-blue. The block also provides per-zone expiry pulses and a
// registered any-zone-active flag.
module pir_zone_motion_rgb #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int N_CH     = 2,
  parameter int HOLD_MS  = 15000,
  parameter int PWM_W    = 8,
  parameter int WARN_LVL = 32,
  parameter int BLINK_MS = 125
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] pir_rise,
  input  logic [N_CH-1:0] pir_on,
  input  logic [1:0]      mode,
  output logic [N_CH-1:0] rgb_r,
  output logic [N_CH-1:0] rgb_g,
  output logic [N_CH-1:0] rgb_b,
  output logic [N_CH-1:0] expired,
  output logic            any_active
);

  localparam int MS_DIV   = CLK_HZ / 1000;
  localparam int LVL_MAX  = (1 << PWM_W) - 1;
  localparam int STEP_RAW = HOLD_MS / LVL_MAX;
  localparam int STEP_MS  = (STEP_RAW < 1) ? 1 : STEP_RAW;
  localparam int DIV_W    = $clog2(MS_DIV);
  localparam int STEP_W   = $clog2(STEP_MS + 1);
  localparam int BLINK_W  = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

  typedef logic [PWM_W-1:0] lvl_t;
  localparam lvl_t LVL_TOP = lvl_t'(LVL_MAX);

  logic [DIV_W-1:0]   ms_div;
  logic               ms_tick;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;
  logic [PWM_W-1:0]   pwm_cnt;

  lvl_t               level    [N_CH];
  logic [STEP_W-1:0]  step     [N_CH];
  lvl_t               r_lvl_p1 [N_CH];
  lvl_t               g_lvl_p1 [N_CH];
  lvl_t               b_lvl_p1 [N_CH];

  // Map a zone level to {red, green, blue} duty levels for the selected mode.
  // The blink only blanks red/green while the zone is still counting down
  // but has fallen under the warning threshold.
  function automatic logic [3*PWM_W-1:0] colour(input lvl_t       lvl,
                                                input logic [1:0] m,
                                                input logic       on,
                                                input logic       phase);
    lvl_t r;
    lvl_t g;
    lvl_t b;
    r = LVL_TOP - lvl;
    g = lvl;
    b = '0;
    case (m)
      2'd1: begin
        if (lvl != '0 && int'(lvl) < WARN_LVL && phase) begin
          r = '0;
          g = '0;
        end
      end
      2'd2: begin
        r = '0;
        g = LVL_TOP;
      end
      2'd3: b = on ? '0 : LVL_TOP;
      default: ;
    endcase
    return {r, g, b};
  endfunction

  // Millisecond divider; ms_tick is a registered one-cycle pulse on wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ms_div  <= '0;
      ms_tick <= 1'b0;
    end else if (ms_div == DIV_W'(MS_DIV - 1)) begin
      ms_div  <= '0;
      ms_tick <= 1'b1;
    end else begin
      ms_div  <= ms_div + 1'b1;
      ms_tick <= 1'b0;
    end
  end

  // Free-running blink phase shared by all zones, toggling every BLINK_MS.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (ms_tick) begin
      if (blink_cnt == BLINK_W'(BLINK_MS - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // ---- stage 0: per-zone level/step counters; a rise always wins over decay.
  // Per-zone level reload/decay and the 1 -> 0 expiry pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        level[i] <= '0;
        step[i]  <= '0;
      end
      expired <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        expired[i] <= 1'b0;
        if (pir_rise[i]) begin
          level[i] <= LVL_TOP;
          step[i]  <= '0;
        end else if (ms_tick && level[i] != '0) begin
          if (step[i] == STEP_W'(STEP_MS - 1)) begin
            step[i]    <= '0;
            level[i]   <= level[i] - 1'b1;
            expired[i] <= (level[i] == lvl_t'(1));
          end else begin
            step[i] <= step[i] + 1'b1;
          end
        end
      end
    end
  end

  // ---- stage 1: colour levels per zone.
  // Register the per-zone colour duty levels from level, mode and blink phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        r_lvl_p1[i] <= '0;
        g_lvl_p1[i] <= '0;
        b_lvl_p1[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        {r_lvl_p1[i], g_lvl_p1[i], b_lvl_p1[i]} <=
          colour(level[i], mode, pir_on[i], blink_phase);
      end
    end
  end

  // Shared PWM ramp, wrapping LVL_MAX -> 0 so full level is never 100% on.
  always_ff @(posedge clk) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + 1'b1;
  end

  // ---- stage 2: PWM compare and pin registers.
  // Red/green are gated by the zone's live pir_on; blue is ungated.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_r      <= '0;
      rgb_g      <= '0;
      rgb_b      <= '0;
      any_active <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        rgb_r[i] <= pir_on[i] & (pwm_cnt < r_lvl_p1[i]);
        rgb_g[i] <= pir_on[i] & (pwm_cnt < g_lvl_p1[i]);
        rgb_b[i] <= (pwm_cnt < b_lvl_p1[i]);
      end
      any_active <= |pir_on;
    end
  end

endmodule

// File: tb/tb_pir_zone_motion_rgb.sv
// Bench for pir_zone_motion_rgb: a cycle model pushes the expected output word
// at every clock edge, and the word is popped and compared on the following
// falling edge. Directed window checks cover duty cycles, blink, collision and
// mid-decay reset.
module tb_pir_zone_motion_rgb;

  localparam int CLK_HZ   = 10_000;
  localparam int MS_DIV   = 10;
  localparam int HOLD_MS  = 300;
  localparam int PWM_W    = 4;
  localparam int LMAX     = 15;
  localparam int STEP     = 20;
  localparam int WARN     = 4;
  localparam int BLINK    = 5;
  localparam int N_CH     = 2;

  logic            clk;
  logic            rst_n;
  logic [N_CH-1:0] pir_rise;
  logic [N_CH-1:0] pir_on;
  logic [1:0]      mode;
  logic [N_CH-1:0] rgb_r, rgb_g, rgb_b, expired;
  logic            any_active;

  pir_zone_motion_rgb #(
    .CLK_HZ(CLK_HZ), .N_CH(N_CH), .HOLD_MS(HOLD_MS), .PWM_W(PWM_W),
    .WARN_LVL(WARN), .BLINK_MS(BLINK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pir_rise(pir_rise), .pir_on(pir_on),
    .mode(mode), .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
    .expired(expired), .any_active(any_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---- reference model
  logic [8:0] sb_q[$];
  int  m_div, m_blk, m_pwm;
  bit  m_tick, m_ph;
  int  m_lvl[N_CH], m_stp[N_CH], m_rl[N_CH], m_gl[N_CH], m_bl[N_CH];
  logic [N_CH-1:0] e_r, e_g, e_b, e_x;
  logic            e_any;
  int  c_r, c_g, c_b;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_div = 0; m_blk = 0; m_pwm = 0; m_tick = 0; m_ph = 0;
      for (int i = 0; i < N_CH; i++) begin
        m_lvl[i] = 0; m_stp[i] = 0; m_rl[i] = 0; m_gl[i] = 0; m_bl[i] = 0;
      end
      e_r = '0; e_g = '0; e_b = '0; e_x = '0; e_any = 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        e_r[i] = pir_on[i] && (m_pwm < m_rl[i]);
        e_g[i] = pir_on[i] && (m_pwm < m_gl[i]);
        e_b[i] = (m_pwm < m_bl[i]);
      end
      e_any = |pir_on;
      for (int i = 0; i < N_CH; i++) begin
        c_r = LMAX - m_lvl[i]; c_g = m_lvl[i]; c_b = 0;
        if (mode == 2'd1 && m_lvl[i] > 0 && m_lvl[i] < WARN && m_ph) begin
          c_r = 0; c_g = 0;
        end
        if (mode == 2'd2) begin c_r = 0; c_g = LMAX; end
        if (mode == 2'd3) c_b = pir_on[i] ? 0 : LMAX;
        m_rl[i] = c_r; m_gl[i] = c_g; m_bl[i] = c_b;
      end
      for (int i = 0; i < N_CH; i++) begin
        e_x[i] = 1'b0;
        if (pir_rise[i]) begin
          m_lvl[i] = LMAX; m_stp[i] = 0;
        end else if (m_tick && m_lvl[i] > 0) begin
          if (m_stp[i] == STEP - 1) begin
            m_stp[i] = 0;
            m_lvl[i] = m_lvl[i] - 1;
            if (m_lvl[i] == 0) e_x[i] = 1'b1;
          end else begin
            m_stp[i] = m_stp[i] + 1;
          end
        end
      end
      if (m_tick) begin
        if (m_blk == BLINK - 1) begin m_blk = 0; m_ph = ~m_ph; end
        else m_blk = m_blk + 1;
      end
      if (m_div == MS_DIV - 1) begin m_div = 0; m_tick = 1; end
      else begin m_div = m_div + 1; m_tick = 0; end
      m_pwm = (m_pwm + 1) % (LMAX + 1);
    end
    sb_q.push_back({e_r, e_g, e_b, e_x, e_any});
  end

  // ---- per-cycle compare and window statistics
  int s_r0, s_g0, s_b0, s_b1, s_x0, s_z1, s_z1rg;
  logic [8:0] exp_w;

  task automatic clr_stats();
    s_r0 = 0; s_g0 = 0; s_b0 = 0; s_b1 = 0; s_x0 = 0; s_z1 = 0; s_z1rg = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    chk("sb_depth", sb_q.size(), 1);
    if (sb_q.size() > 0) begin
      exp_w = sb_q.pop_front();
      chk("sb_out", {rgb_r, rgb_g, rgb_b, expired, any_active}, exp_w);
    end
    if (rgb_r[0]) s_r0++;
    if (rgb_g[0]) s_g0++;
    if (rgb_b[0]) s_b0++;
    if (rgb_b[1]) s_b1++;
    if (expired[0]) s_x0++;
    if (rgb_r[1] | rgb_g[1] | rgb_b[1]) s_z1++;
    if (rgb_r[1] | rgb_g[1]) s_z1rg++;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wait_lvl(input int v, input int bound, input string tag);
    int n;
    n = 0;
    while (int'(dut.level[0]) != v && n < bound) begin
      tick();
      n++;
    end
    chk(tag, 32'(dut.level[0]), v);
  endtask

  task automatic pulse_rise0();
    pir_rise = 2'b01;
    tick();
    pir_rise = 2'b00;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n, run, maxrun;

  initial begin
    rst_n = 1'b0; pir_rise = '0; pir_on = 2'b11; mode = 2'd0;
    clr_stats();

    // Scenario 1: reset hold and first ms tick
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("rst_hold", {rgb_r, rgb_g, rgb_b, expired, any_active}, 9'd0);
    end
    rst_n = 1'b1;
    tick();
    chk("any_act", any_active, 1);
    n = 1;
    while (!dut.ms_tick && n < 20) begin
      tick();
      n++;
    end
    chk("first_tick", n, 10);

    // Scenario 2: full decay in mode 0
    pir_on = 2'b01; mode = 2'd0;
    ticks(3);
    clr_stats();
    pulse_rise0();
    n = 0;
    ticks(20); n += 20;
    s_r0 = 0; s_g0 = 0;
    ticks(160); n += 160;
    chk("g0_full", s_g0, 150);
    chk("r0_full", s_r0, 0);
    while (!expired[0] && n < 3500) begin
      tick();
      n++;
    end
    chk("decay_time", (n >= 2991 && n <= 3000), 1);
    ticks(20);
    s_r0 = 0; s_g0 = 0;
    ticks(160);
    chk("r0_empty", s_r0, 150);
    chk("g0_empty", s_g0, 0);
    chk("x0_once", s_x0, 1);
    chk("z1_dark", s_z1, 0);

    // Scenario 3: rise collides with the decrementing ms tick at level 8
    pulse_rise0();
    n = 0;
    while (!(int'(dut.level[0]) == 8 && int'(dut.step[0]) == STEP - 1 &&
             int'(dut.ms_div) == MS_DIV - 1) && n < 3000) begin
      tick();
      n++;
    end
    chk("coll_found", (n < 3000), 1);
    tick();
    chk("coll_tick", dut.ms_tick, 1);
    clr_stats();
    pulse_rise0();
    chk("coll_lvl", 32'(dut.level[0]), 15);
    chk("coll_step", 32'(dut.step[0]), 0);
    ticks(30);
    chk("coll_noexp", s_x0, 0);

    // Scenario 4: warning blink in mode 1
    mode = 2'd1;
    wait_lvl(4, 3000, "reach_l4");
    ticks(5);
    run = 0; maxrun = 0;
    for (int k = 0; k < 150; k++) begin
      tick();
      if (!(rgb_r[0] | rgb_g[0])) run++; else run = 0;
      if (run > maxrun) maxrun = run;
    end
    chk("warn4_run", maxrun, 5);
    wait_lvl(3, 300, "reach_l3");
    ticks(5);
    run = 0; maxrun = 0; s_r0 = 0;
    for (int k = 0; k < 190; k++) begin
      tick();
      if (!(rgb_r[0] | rgb_g[0])) run++; else run = 0;
      if (run > maxrun) maxrun = run;
    end
    chk("warn3_blink", (maxrun >= 50), 1);
    chk("warn3_pwm", (s_r0 > 0), 1);

    // Scenario 5: idle-blue with both zones at level 0
    wait_lvl(0, 1000, "reach_l0");
    mode = 2'd3; pir_on = 2'b01;
    ticks(5);
    clr_stats();
    ticks(160);
    chk("b1_idle", s_b1, 150);
    chk("b0_off", s_b0, 0);
    chk("z1_rg_off", s_z1rg, 0);

    // Scenario 6: reset mid-decay at level 9
    mode = 2'd0; pir_on = 2'b01;
    pulse_rise0();
    wait_lvl(9, 2000, "reach_l9");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_lvl", 32'(dut.level[0]), 0);
    chk("mid_rst_out", {rgb_r, rgb_g, rgb_b, expired, any_active}, 9'd0);
    clr_stats();
    ticks(400);
    chk("mid_rst_noexp", s_x0, 0);
    chk("mid_rst_g0", s_g0, 0);
    pulse_rise0();
    ticks(20);
    clr_stats();
    ticks(160);
    chk("resume_g0", s_g0, 150);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
